// File: rtl/cs_pkg.sv
// Shared types and constants for the contrast-stretch engine and its divider.
package cs_pkg;
  typedef enum logic [2:0] {IDLE, SCAN, DIV, MAP, DONE} cs_state_e;

  localparam int GAIN_WIDTH = 24;
  localparam int PIX_MAX    = 255;
endpackage

// File: rtl/seq_divider.sv
// Restoring divider, one quotient bit per cycle: 1 load cycle + DIVIDEND_W iterations.
// o_done is high during the final iteration; o_quotient is valid from the next cycle.
module seq_divider #(
  parameter int DIVIDEND_W = 24,
  parameter int DIVISOR_W  = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [DIVIDEND_W-1:0] i_dividend,
  input  logic [DIVISOR_W-1:0]  i_divisor,
  output logic [DIVIDEND_W-1:0] o_quotient,
  output logic                  o_done
);
  localparam int CNT_W = $clog2(DIVIDEND_W + 1);

  logic [DIVISOR_W-1:0]  r_rem;
  logic [DIVISOR_W-1:0]  r_dvs;
  logic [DIVIDEND_W-1:0] r_quo;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_busy;

  logic [DIVISOR_W:0]    w_shift;
  logic [DIVISOR_W:0]    w_diff;
  logic                  w_fits;

  // Remainder stays below the divisor, so the shifted value fits DIVISOR_W+1 bits.
  assign w_shift = {r_rem, r_quo[DIVIDEND_W-1]};
  assign w_diff  = w_shift - {1'b0, r_dvs};
  assign w_fits  = ~w_diff[DIVISOR_W];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rem  <= '0;
      r_dvs  <= '0;
      r_quo  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_rem  <= '0;
      r_dvs  <= i_divisor;
      r_quo  <= i_dividend;
      r_cnt  <= CNT_W'(DIVIDEND_W);
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_rem  <= w_fits ? w_diff[DIVISOR_W-1:0] : w_shift[DIVISOR_W-1:0];
      r_quo  <= {r_quo[DIVIDEND_W-2:0], w_fits};
      r_cnt  <= r_cnt - CNT_W'(1);
      if (r_cnt == CNT_W'(1)) r_busy <= 1'b0;
    end
  end

  assign o_quotient = r_quo;
  assign o_done     = r_busy && (r_cnt == CNT_W'(1));
endmodule

// File: rtl/contrast_stretch.sv
// Two-pass contrast stretch: scan for min/max, divide for a fixed-point gain,
// then re-read the frame and emit remapped pixels one per cycle.
module contrast_stretch
  import cs_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int RAM_DEPTH  = 76800,
  parameter int ADDR_WIDTH = $clog2(RAM_DEPTH),
  parameter int FRAC_BITS  = 16
) (
  input  logic                  clk_i_cs,
  input  logic                  rst_i_cs,
  input  logic                  start_i_cs,
  output logic                  en_o_cs,
  output logic                  re_o_cs,
  output logic [ADDR_WIDTH-1:0] address_o_cs,
  input  logic [DATA_WIDTH-1:0] data_i_cs,
  output logic [DATA_WIDTH-1:0] pix_o_cs,
  output logic [ADDR_WIDTH-1:0] pix_addr_o_cs,
  output logic                  pix_we_o_cs,
  output logic [DATA_WIDTH-1:0] min_o_cs,
  output logic [DATA_WIDTH-1:0] max_o_cs,
  output logic                  busy_o_cs,
  output logic                  done_o_cs
);
  localparam int PROD_W = DATA_WIDTH + GAIN_WIDTH;
  localparam logic [GAIN_WIDTH-1:0] DIVIDEND = GAIN_WIDTH'(PIX_MAX << FRAC_BITS);
  localparam logic [PROD_W-1:0]     HALF     = PROD_W'(1) << (FRAC_BITS - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST     = ADDR_WIDTH'(RAM_DEPTH - 1);

  cs_state_e             r_state;
  logic                  r_en;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [1:0]            r_vld_pipe;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic [DATA_WIDTH-1:0] r_min;
  logic [DATA_WIDTH-1:0] r_max;
  logic                  r_bypass;
  logic                  r_div_started;
  logic [DATA_WIDTH-1:0] r_pix;
  logic [ADDR_WIDTH-1:0] r_pix_addr;
  logic                  r_busy;
  logic                  r_done;

  logic                  w_last;
  logic [DATA_WIDTH-1:0] w_range;
  logic                  w_div_start;
  logic                  w_div_done;
  logic [GAIN_WIDTH-1:0] w_gain;
  logic [DATA_WIDTH-1:0] w_delta;
  logic [PROD_W-1:0]     w_prod;
  logic [PROD_W-1:0]     w_round;
  logic [DATA_WIDTH-1:0] w_pix;
  logic                  w_map_vld;
  logic                  w_unused_frac;

  assign w_last      = (r_addr == LAST);
  assign w_range     = r_max - r_min;
  assign w_div_start = (r_state == DIV) && !r_div_started && (w_range != '0);
  assign w_map_vld   = (r_state == MAP) && r_vld_pipe[0];

  seq_divider #(
    .DIVIDEND_W (GAIN_WIDTH),
    .DIVISOR_W  (DATA_WIDTH)
  ) u_div (
    .i_clk      (clk_i_cs),
    .i_rst      (rst_i_cs),
    .i_start    (w_div_start),
    .i_dividend (DIVIDEND),
    .i_divisor  (w_range),
    .o_quotient (w_gain),
    .o_done     (w_div_done)
  );

  assign w_delta       = data_i_cs - r_min;
  assign w_prod        = PROD_W'(w_delta) * PROD_W'(w_gain);
  assign w_round       = w_prod + HALF;
  assign w_pix         = r_bypass ? data_i_cs : w_round[FRAC_BITS +: DATA_WIDTH];
  assign w_unused_frac = ^w_round[FRAC_BITS-1:0];

  always_ff @(posedge clk_i_cs) begin
    if (rst_i_cs) begin
      r_state       <= IDLE;
      r_en          <= 1'b0;
      r_addr        <= '0;
      r_vld_pipe    <= '0;
      r_rd_addr     <= '0;
      r_min         <= '0;
      r_max         <= '0;
      r_bypass      <= 1'b0;
      r_div_started <= 1'b0;
      r_pix         <= '0;
      r_pix_addr    <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_done        <= 1'b0;
      r_vld_pipe[0] <= r_en;
      r_vld_pipe[1] <= w_map_vld;
      r_rd_addr     <= r_addr;
      r_pix_addr    <= r_rd_addr;
      if (w_map_vld) r_pix <= w_pix;

      case (r_state)
        IDLE: if (start_i_cs) begin
          r_min         <= DATA_WIDTH'(PIX_MAX);
          r_max         <= '0;
          r_bypass      <= 1'b0;
          r_div_started <= 1'b0;
          r_en          <= 1'b1;
          r_addr        <= '0;
          r_busy        <= 1'b1;
          r_state       <= SCAN;
        end
        SCAN: begin
          if (r_vld_pipe[0]) begin
            if (data_i_cs < r_min) r_min <= data_i_cs;
            if (data_i_cs > r_max) r_max <= data_i_cs;
          end
          // Terminal-count stop; the trailing cycle collects the last sample.
          if (r_en) begin
            if (w_last) begin
              r_en   <= 1'b0;
              r_addr <= '0;
            end else begin
              r_addr <= r_addr + ADDR_WIDTH'(1);
            end
          end else begin
            r_state <= DIV;
          end
        end
        DIV: begin
          if (!r_div_started) begin
            if (w_range == '0) begin
              r_bypass <= 1'b1;
              r_en     <= 1'b1;
              r_addr   <= '0;
              r_state  <= MAP;
            end else begin
              r_div_started <= 1'b1;
            end
          end else if (w_div_done) begin
            r_en    <= 1'b1;
            r_addr  <= '0;
            r_state <= MAP;
          end
        end
        MAP: begin
          if (r_en) begin
            if (w_last) begin
              r_en   <= 1'b0;
              r_addr <= '0;
            end else begin
              r_addr <= r_addr + ADDR_WIDTH'(1);
            end
          end
          if (r_vld_pipe[1] && (r_pix_addr == LAST)) begin
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // The gain is floor(255/range) scaled, so a rounded result above 255 means a broken gain.
  always_ff @(posedge clk_i_cs) begin
    if (!rst_i_cs && w_map_vld && !r_bypass)
      assert (w_round[PROD_W-1:FRAC_BITS+DATA_WIDTH] == '0);
  end

  assign en_o_cs       = r_en;
  assign re_o_cs       = r_en;
  assign address_o_cs  = r_addr;
  assign pix_o_cs      = r_pix;
  assign pix_addr_o_cs = r_pix_addr;
  assign pix_we_o_cs   = r_vld_pipe[1];
  assign min_o_cs      = r_min;
  assign max_o_cs      = r_max;
  assign busy_o_cs     = r_busy;
  assign done_o_cs     = r_done;
endmodule

// File: tb/tb_contrast_stretch.sv
// Directed bench for contrast_stretch with a 16-pixel frame and a 1-cycle RAM model.
module tb_contrast_stretch;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int DW    = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          en, re;
  logic [AW-1:0] addr;
  logic [DW-1:0] rdata;
  logic [DW-1:0] pix;
  logic [AW-1:0] pix_addr;
  logic          pix_we;
  logic [DW-1:0] mn, mx;
  logic          busy, done;

  contrast_stretch #(
    .DATA_WIDTH (DW),
    .RAM_DEPTH  (DEPTH),
    .ADDR_WIDTH (AW),
    .FRAC_BITS  (16)
  ) dut (
    .clk_i_cs      (clk),
    .rst_i_cs      (rst),
    .start_i_cs    (start),
    .en_o_cs       (en),
    .re_o_cs       (re),
    .address_o_cs  (addr),
    .data_i_cs     (rdata),
    .pix_o_cs      (pix),
    .pix_addr_o_cs (pix_addr),
    .pix_we_o_cs   (pix_we),
    .min_o_cs      (mn),
    .max_o_cs      (mx),
    .busy_o_cs     (busy),
    .done_o_cs     (done)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) if (en && re) rdata <= mem[addr];

  // Output capture, sampled mid-cycle.
  int cap_n = 0;
  int done_n = 0;
  logic [DW-1:0] cap_pix  [256];
  logic [AW-1:0] cap_addr [256];
  always @(negedge clk) begin
    if (pix_we) begin
      if (cap_n < 256) begin
        cap_pix[cap_n]  = pix;
        cap_addr[cap_n] = pix_addr;
      end
      cap_n++;
    end
    if (done) done_n++;
  end

  typedef struct {
    logic [DW-1:0] pix;
    logic [DW-1:0] exp;
  } vec_t;
  vec_t tbl [48];

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string name, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " en"},       int'(en),       0);
    chk({tag, " re"},       int'(re),       0);
    chk({tag, " addr"},     int'(addr),     0);
    chk({tag, " pix"},      int'(pix),      0);
    chk({tag, " pix_addr"}, int'(pix_addr), 0);
    chk({tag, " pix_we"},   int'(pix_we),   0);
    chk({tag, " min"},      int'(mn),       0);
    chk({tag, " max"},      int'(mx),       0);
    chk({tag, " busy"},     int'(busy),     0);
    chk({tag, " done"},     int'(done),     0);
  endtask

  task automatic load(input int base);
    for (int i = 0; i < DEPTH; i++) mem[i] = tbl[base + i].pix;
  endtask

  // Entered #1 after a rising edge; start is high for the first cycle counted.
  task automatic run_frame(input string tag, input int base, input int exp_cyc,
                           input int emin, input int emax, input int egain,
                           input bit poke_start);
    int c0, d0, n;
    load(base);
    c0 = cap_n;
    d0 = done_n;
    n  = 0;
    start = 1'b1;
    while (n < 300) begin
      @(posedge clk);
      n++;
      #1;
      if (n == 1) start = 1'b0;
      if (poke_start && n == 5) start = 1'b1;
      if (poke_start && n == 6) start = 1'b0;
      if (done) break;
    end
    chk({tag, " cycles to done"}, n, exp_cyc);
    chk({tag, " min"}, int'(mn), emin);
    chk({tag, " max"}, int'(mx), emax);
    if (egain >= 0) chk({tag, " gain"}, int'(dut.w_gain), egain);
    chk({tag, " pixel count"}, cap_n - c0, DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      if (c0 + i < 256) begin
        chk($sformatf("%s addr[%0d]", tag, i), int'(cap_addr[c0 + i]), i);
        chk($sformatf("%s pix[%0d]", tag, i), int'(cap_pix[c0 + i]), int'(tbl[base + i].exp));
      end
    end
    @(posedge clk);
    #1;
    chk({tag, " done width"}, int'(done), 0);
    chk({tag, " busy after"}, int'(busy), 0);
    chk({tag, " done pulses"}, done_n - d0, 1);
    chk({tag, " min hold"}, int'(mn), emin);
  endtask

  logic [DW-1:0] full_px [16] = '{8'd0, 8'd255, 8'd1, 8'd128, 8'd200, 8'd17, 8'd99, 8'd254,
                                  8'd3, 8'd64, 8'd180, 8'd45, 8'd230, 8'd12, 8'd7, 8'd150};

  initial begin
    int c0, n;
    // Ramp: 50+5i, gain 222822 maps each step of 5 to exactly 17.
    for (int i = 0; i < 16; i++) begin
      tbl[i].pix      = 8'(50 + 5 * i);
      tbl[i].exp      = 8'(17 * i);
      tbl[16 + i].pix = 8'd77;
      tbl[16 + i].exp = 8'd77;
      tbl[32 + i].pix = full_px[i];
      tbl[32 + i].exp = full_px[i];
    end

    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("idle busy", int'(busy), 0);

    run_frame("ramp", 0, 61, 50, 125, 222822, 1'b1);
    run_frame("flat", 16, 37, 77, 77, -1, 1'b0);
    run_frame("full", 32, 61, 0, 255, 65536, 1'b0);

    // Reset while pixel 7 is on the output.
    load(0);
    start = 1'b1;
    n = 0;
    while (n < 300) begin
      @(posedge clk);
      n++;
      #1;
      start = 1'b0;
      if (pix_we && pix_addr == AW'(7)) break;
    end
    chk("reach pixel 7", int'(n < 300), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_zero("mid-map reset");
    chk("mid-map state idle", int'(dut.r_state == cs_pkg::IDLE), 1);
    rst = 1'b0;
    c0 = cap_n;
    repeat (10) @(posedge clk);
    #1;
    chk("no stale pix_we", cap_n - c0, 0);
    chk("idle after reset", int'(busy), 0);

    run_frame("restart", 0, 61, 50, 125, 222822, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
